// File: rtl/bp_pkg.sv
// Shared widths, the resolve payload record and ROB-age helper for the
// branch-predictor update scheduler.
package bp_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned PHT_ADDRESS = 9;
  localparam int unsigned GHR_SIZE    = 9;
  localparam int unsigned RAS_ADDRESS = 3;
  localparam int unsigned ROB_TAG_W   = 5;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [XLEN-1:0]        target;
    logic [XLEN-1:0]        ret_addr;
    logic                   taken;
    logic                   is_branch;
    logic                   is_ret;
    logic                   is_call;
    logic                   mispredict;
    logic [PHT_ADDRESS-1:0] pht_index;
    logic [GHR_SIZE-1:0]    ghr_snap;
    logic [RAS_ADDRESS-1:0] sp_snap;
    logic [2*XLEN-1:0]      ras_snap;
    logic [ROB_TAG_W-1:0]   rob_tag;
  } bp_update_t;

  // True when tag a is strictly older than tag b, ages taken modulo the tag
  // width relative to the current ROB head.
  function automatic logic older(input logic [ROB_TAG_W-1:0] a,
                                 input logic [ROB_TAG_W-1:0] b,
                                 input logic [ROB_TAG_W-1:0] head);
    logic [ROB_TAG_W-1:0] age_a;
    logic [ROB_TAG_W-1:0] age_b;
    age_a = a - head;
    age_b = b - head;
    return age_a < age_b;
  endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Pending-update queue: circular buffer with 2-wide push, 1-wide pop and a
// kill of every entry younger than a given ROB tag (survivors are compacted).
module bp_update_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      push0,
  input  bp_update_t                push0_data,
  input  logic                      push1,
  input  bp_update_t                push1_data,
  input  logic                      pop,
  input  logic                      kill,
  input  logic [ROB_TAG_W-1:0]      kill_tag,
  input  logic [ROB_TAG_W-1:0]      rob_head,
  output bp_update_t                head_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  bp_update_t       mem    [DEPTH];
  bp_update_t       mem_nx [DEPTH];
  bp_update_t       cmp    [DEPTH];
  bp_update_t       view;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] n;

  // Build the next logical contents (drop popped/killed entries, append
  // pushes in order) and lay them back down starting at the new read pointer.
  // Untouched entries are rewritten with their own value, so the plain
  // push/pop case still behaves as an ordinary wrapping ring.
  always_comb begin
    cmp    = '{default: '0};
    mem_nx = mem;
    view   = '0;
    n      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      view = mem[rd_ptr + PTR_W'(i)];
      if ((CNT_W'(i) < cnt) && !(pop && i == 0) &&
          !(kill && older(kill_tag, view.rob_tag, rob_head))) begin
        cmp[n[PTR_W-1:0]] = view;
        n = n + CNT_W'(1);
      end
    end
    if (push0) begin
      cmp[n[PTR_W-1:0]] = push0_data;
      n = n + CNT_W'(1);
    end
    if (push1) begin
      cmp[n[PTR_W-1:0]] = push1_data;
      n = n + CNT_W'(1);
    end
    rd_nx = (pop && cnt != '0) ? rd_ptr + PTR_W'(1) : rd_ptr;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < n) mem_nx[rd_nx + PTR_W'(i)] = cmp[PTR_W'(i)];
    end
    cnt_nx = flush ? '0 : n;
  end

  // Queue state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      cnt    <= '0;
      mem    <= '{default: '0};
    end else begin
      rd_ptr <= rd_nx;
      cnt    <= cnt_nx;
      mem    <= mem_nx;
    end
  end

  assign head_data = mem[rd_ptr];
  assign count     = cnt;
  assign empty     = (cnt == '0);

endmodule

// File: rtl/bp_update_sched.sv
// Schedules branch resolutions from two execute units onto the single
// predictor update/recovery port; mispredicts bypass the queue.
module bp_update_sched
  import bp_pkg::*;
#(
  parameter int unsigned Q_DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   rs0_valid,
  input  logic                   rs1_valid,
  input  bp_update_t             rs0_upd,
  input  bp_update_t             rs1_upd,
  output logic                   rs_ready,
  input  logic [ROB_TAG_W-1:0]   rob_head,
  input  logic                   ext_flush,
  output logic                   mispredict,
  output logic                   restore_ghr,
  output logic                   restore_ras,
  output logic                   update_pht,
  output logic                   update_btb,
  output logic                   update_ras,
  output logic                   actual_taken,
  output logic                   ex_is_branch,
  output logic                   ex_is_ret,
  output logic [XLEN-1:0]        ex_pc,
  output logic [XLEN-1:0]        actual_target_address,
  output logic [XLEN-1:0]        actual_return_address,
  output logic [GHR_SIZE-1:0]    ghr_snap,
  output logic [PHT_ADDRESS-1:0] rb_pht_index,
  output logic [RAS_ADDRESS-1:0] rb_sp_snap,
  output logic [2*XLEN-1:0]      rb_ras_snap
);

  localparam int unsigned CNT_W = $clog2(Q_DEPTH) + 1;

  logic [CNT_W-1:0]     q_count;
  logic                 q_empty;
  bp_update_t           q_head;
  logic                 last_mp_valid;
  logic [ROB_TAG_W-1:0] last_mp_tag;

  logic       surv0, surv1, mp0, mp1, mp_any, sel1, other_surv, load;
  logic       push0, push1, pop, swap;
  bp_update_t win, other, pd0, pd1, src;

  assign rs_ready = (q_count <= CNT_W'(Q_DEPTH - 2));

  // Input filtering, mispredict arbitration and queue control.
  always_comb begin
    surv0 = rs0_valid && rs_ready &&
            !(last_mp_valid && older(last_mp_tag, rs0_upd.rob_tag, rob_head));
    surv1 = rs1_valid && rs_ready &&
            !(last_mp_valid && older(last_mp_tag, rs1_upd.rob_tag, rob_head));
    mp0    = surv0 && rs0_upd.mispredict;
    mp1    = surv1 && rs1_upd.mispredict;
    mp_any = mp0 || mp1;
    sel1   = mp1 && (!mp0 || older(rs1_upd.rob_tag, rs0_upd.rob_tag, rob_head));
    win        = sel1 ? rs1_upd : rs0_upd;
    other      = sel1 ? rs0_upd : rs1_upd;
    other_surv = sel1 ? surv0 : surv1;
    swap       = older(rs1_upd.rob_tag, rs0_upd.rob_tag, rob_head);
    push0 = 1'b0;
    push1 = 1'b0;
    pop   = 1'b0;
    pd0   = rs0_upd;
    pd1   = rs1_upd;
    if (mp_any) begin
      push0 = other_surv && !other.mispredict &&
              older(other.rob_tag, win.rob_tag, rob_head);
      pd0   = other;
    end else begin
      pop = !q_empty;
      if (surv0 && surv1) begin
        push0 = 1'b1;
        push1 = 1'b1;
        pd0   = swap ? rs1_upd : rs0_upd;
        pd1   = swap ? rs0_upd : rs1_upd;
      end else if (surv0) begin
        push0 = 1'b1;
        pd0   = rs0_upd;
      end else if (surv1) begin
        push0 = 1'b1;
        pd0   = rs1_upd;
      end
    end
    load = mp_any || !q_empty;
    src  = mp_any ? win : q_head;
  end

  bp_update_fifo #(.DEPTH(Q_DEPTH)) u_fifo (
    .clk        (CLK),
    .reset      (reset),
    .flush      (ext_flush),
    .push0      (push0),
    .push0_data (pd0),
    .push1      (push1),
    .push1_data (pd1),
    .pop        (pop),
    .kill       (mp_any),
    .kill_tag   (win.rob_tag),
    .rob_head   (rob_head),
    .head_data  (q_head),
    .count      (q_count),
    .empty      (q_empty)
  );

  // Strobe pulses and mispredict tracking. A mispredict always writes the
  // BTB, so folding the record's mispredict bit into the BTB strobe covers
  // both the bypass and the queue path with one expression.
  always_ff @(posedge CLK) begin
    if (reset || ext_flush) begin
      mispredict    <= 1'b0;
      restore_ghr   <= 1'b0;
      restore_ras   <= 1'b0;
      update_pht    <= 1'b0;
      update_btb    <= 1'b0;
      update_ras    <= 1'b0;
      last_mp_valid <= 1'b0;
      last_mp_tag   <= '0;
    end else begin
      mispredict    <= mp_any;
      restore_ghr   <= mp_any;
      restore_ras   <= mp_any;
      update_pht    <= load && src.is_branch;
      update_btb    <= load && (src.taken || src.is_ret || src.mispredict);
      update_ras    <= load && src.is_call;
      last_mp_valid <= mp_any;
      if (mp_any) last_mp_tag <= src.rob_tag;
    end
  end

  // Data outputs load with each issued update and hold otherwise.
  always_ff @(posedge CLK) begin
    if (reset || ext_flush) begin
      actual_taken          <= 1'b0;
      ex_is_branch          <= 1'b0;
      ex_is_ret             <= 1'b0;
      ex_pc                 <= '0;
      actual_target_address <= '0;
      actual_return_address <= '0;
      ghr_snap              <= '0;
      rb_pht_index          <= '0;
      rb_sp_snap            <= '0;
      rb_ras_snap           <= '0;
    end else if (load) begin
      actual_taken          <= src.taken;
      ex_is_branch          <= src.is_branch;
      ex_is_ret             <= src.is_ret;
      ex_pc                 <= src.pc;
      actual_target_address <= src.target;
      actual_return_address <= src.ret_addr;
      ghr_snap              <= src.ghr_snap;
      rb_pht_index          <= src.pht_index;
      rb_sp_snap            <= src.sp_snap;
      rb_ras_snap           <= src.ras_snap;
    end
  end

endmodule

// File: tb/tb_bp_update_sched.sv
// Directed bench for bp_update_sched with hand-computed expectations.
module tb_bp_update_sched;
  import bp_pkg::*;

  logic                   CLK = 1'b0;
  logic                   reset, rs0_valid, rs1_valid, rs_ready, ext_flush;
  bp_update_t             rs0_upd, rs1_upd;
  logic [ROB_TAG_W-1:0]   rob_head;
  logic                   mispredict, restore_ghr, restore_ras;
  logic                   update_pht, update_btb, update_ras;
  logic                   actual_taken, ex_is_branch, ex_is_ret;
  logic [XLEN-1:0]        ex_pc, actual_target_address, actual_return_address;
  logic [GHR_SIZE-1:0]    ghr_snap;
  logic [PHT_ADDRESS-1:0] rb_pht_index;
  logic [RAS_ADDRESS-1:0] rb_sp_snap;
  logic [2*XLEN-1:0]      rb_ras_snap;
  logic [5:0]             stb;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  assign stb = {mispredict, restore_ghr, restore_ras, update_pht, update_btb, update_ras};

  bp_update_sched #(.Q_DEPTH(4)) dut (
    .CLK(CLK), .reset(reset),
    .rs0_valid(rs0_valid), .rs1_valid(rs1_valid),
    .rs0_upd(rs0_upd), .rs1_upd(rs1_upd),
    .rs_ready(rs_ready), .rob_head(rob_head), .ext_flush(ext_flush),
    .mispredict(mispredict), .restore_ghr(restore_ghr), .restore_ras(restore_ras),
    .update_pht(update_pht), .update_btb(update_btb), .update_ras(update_ras),
    .actual_taken(actual_taken), .ex_is_branch(ex_is_branch), .ex_is_ret(ex_is_ret),
    .ex_pc(ex_pc), .actual_target_address(actual_target_address),
    .actual_return_address(actual_return_address), .ghr_snap(ghr_snap),
    .rb_pht_index(rb_pht_index), .rb_sp_snap(rb_sp_snap), .rb_ras_snap(rb_ras_snap)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // strobes as {mp, rghr, rras, pht, btb, ras}
  task automatic expect_out(input string name, input logic [5:0] s, input logic [31:0] pc);
    check({name, "_stb"}, {58'd0, stb}, {58'd0, s});
    check({name, "_pc"}, {32'd0, ex_pc}, {32'd0, pc});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic bp_update_t mk(input logic [31:0] pc, input logic [4:0] tag,
                                    input logic mp, input logic taken, input logic br,
                                    input logic call, input logic ret);
    bp_update_t u;
    u           = '0;
    u.pc        = pc;
    u.target    = pc + 32'h40;
    u.ret_addr  = pc + 32'h4;
    u.taken     = taken;
    u.is_branch = br;
    u.is_call   = call;
    u.is_ret    = ret;
    u.mispredict = mp;
    u.pht_index = pc[10:2];
    u.ghr_snap  = {4'b0, tag};
    u.sp_snap   = tag[2:0];
    u.ras_snap  = {pc, ~pc};
    u.rob_tag   = tag;
    return u;
  endfunction

  task automatic drive(input logic v0, input bp_update_t u0, input logic v1, input bp_update_t u1);
    rs0_valid = v0;
    rs0_upd   = u0;
    rs1_valid = v1;
    rs1_upd   = u1;
  endtask

  task automatic idle();
    rs0_valid = 1'b0;
    rs1_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ext_flush = 1'b0;
    rob_head = '0;
    rs0_upd = '0;
    rs1_upd = '0;
    idle();
    tick();
    tick();
    expect_out("rst", 6'b000000, 32'h0);
    check("rst_ras", rb_ras_snap, 64'h0);
    check("rst_ghr", {55'd0, ghr_snap}, 64'h0);
    check("rst_ready", {63'd0, rs_ready}, 64'h1);
    reset = 1'b0;

    // 1: non-mispredict branch takes two cycles
    drive(1'b1, mk(32'h100, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, '0);
    tick(); idle();
    check("t1_q_stb", {58'd0, stb}, 64'h0);
    tick();
    expect_out("t1_issue", 6'b000110, 32'h100);
    check("t1_tgt", {32'd0, actual_target_address}, 64'h140);
    check("t1_taken", {63'd0, actual_taken}, 64'h1);
    tick();
    expect_out("t1_hold", 6'b000000, 32'h100);

    // 2: two mispredicts, older (rs1 tag 4) wins; younger-than-mp input dropped next cycle
    drive(1'b1, mk(32'h700, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0),
          1'b1, mk(32'h400, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    tick();
    expect_out("t2_mp", 6'b111011, 32'h400);
    check("t2_ras", rb_ras_snap, 64'h00000400_FFFFFBFF);
    check("t2_ret", {32'd0, actual_return_address}, 64'h404);
    drive(1'b1, mk(32'h600, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0),
          1'b1, mk(32'h200, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(); idle();
    expect_out("t2_drop", 6'b000000, 32'h400);
    tick();
    expect_out("t2_old", 6'b000100, 32'h200);
    repeat (3) begin
      tick();
      expect_out("t2_none", 6'b000000, 32'h200);
    end

    // 3: queue [2,5,9] built around mp 10; mp 6 kills 9
    drive(1'b1, mk(32'h20, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0),
          1'b1, mk(32'h50, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();
    expect_out("t3_fill", 6'b000000, 32'h200);
    drive(1'b1, mk(32'h90, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1),
          1'b1, mk(32'hA0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tick(); idle();
    expect_out("t3_mp10", 6'b111110, 32'hA0);
    check("t3_full", {63'd0, rs_ready}, 64'h0);
    tick();
    expect_out("t3_t2", 6'b000110, 32'h20);
    check("t3_ready", {63'd0, rs_ready}, 64'h1);
    drive(1'b1, mk(32'h60, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0, '0);
    tick(); idle();
    expect_out("t3_mp6", 6'b111110, 32'h60);
    tick();
    expect_out("t3_t5", 6'b000100, 32'h50);
    repeat (3) begin
      tick();
      expect_out("t3_no9", 6'b000000, 32'h50);
    end

    // 4: tag wraparound, head=30
    rob_head = 5'd30;
    drive(1'b1, mk(32'h1000, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0),
          1'b1, mk(32'h3100, 5'd31, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tick(); idle();
    expect_out("t4_mp", 6'b111110, 32'h1000);
    tick();
    expect_out("t4_t31", 6'b000110, 32'h3100);
    rob_head = 5'd0;
    tick();
    expect_out("t4_idle", 6'b000000, 32'h3100);

    // equal tags: unit 0 wins, other mispredict not queued
    drive(1'b1, mk(32'h801, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0),
          1'b1, mk(32'h802, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(); idle();
    expect_out("eq_u0", 6'b111110, 32'h801);
    tick();
    expect_out("eq_none", 6'b000000, 32'h801);

    // 5: fill to Q_DEPTH-1, inputs ignored while not ready
    drive(1'b1, mk(32'hA1, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
          1'b1, mk(32'hA2, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();
    expect_out("t5_a", 6'b000000, 32'h801);
    check("t5_a_rdy", {63'd0, rs_ready}, 64'h1);
    drive(1'b1, mk(32'hA3, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
          1'b1, mk(32'hA4, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();
    expect_out("t5_b", 6'b000100, 32'hA1);
    check("t5_b_rdy", {63'd0, rs_ready}, 64'h0);
    drive(1'b1, mk(32'hB5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
          1'b1, mk(32'hB6, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(); idle();
    expect_out("t5_c", 6'b000100, 32'hA2);
    check("t5_c_rdy", {63'd0, rs_ready}, 64'h1);
    tick();
    expect_out("t5_d", 6'b000100, 32'hA3);
    tick();
    expect_out("t5_e", 6'b000100, 32'hA4);
    tick();
    expect_out("t5_end", 6'b000000, 32'hA4);

    // 6: ext_flush with a full-ish queue and a same-cycle mispredict
    drive(1'b1, mk(32'hC1, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
          1'b1, mk(32'hC2, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();
    drive(1'b1, mk(32'hC3, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
          1'b1, mk(32'hC4, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();
    check("t6_full", {63'd0, rs_ready}, 64'h0);
    ext_flush = 1'b1;
    drive(1'b1, mk(32'hF0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, '0);
    tick(); ext_flush = 1'b0; idle();
    expect_out("t6_flush", 6'b000000, 32'h0);
    check("t6_rdy", {63'd0, rs_ready}, 64'h1);
    repeat (3) begin
      tick();
      expect_out("t6_quiet", 6'b000000, 32'h0);
    end
    ext_flush = 1'b1;
    drive(1'b1, mk(32'hF4, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, '0);
    tick(); ext_flush = 1'b0; idle();
    expect_out("t6_flush2", 6'b000000, 32'h0);
    tick();
    expect_out("t6_quiet2", 6'b000000, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
